cc_sar_search: RTL
==================

CC_SAR_SEARCH -- requirements
Module: CC_SAR_SEARCH

Interface
REQ-001 SHALL have parameter NUMBER_DATAWIDTH, default 8, the width of the trial and result buses (minimum 2).
REQ-002 SHALL have port CC_SAR_SEARCH_CLOCK_50  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port CC_SAR_SEARCH_RESET_InLow  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port CC_SAR_SEARCH_start_In  input  1  search request, sampled only in IDLE.
REQ-005 SHALL have port CC_SAR_SEARCH_greaterthan_In  input  1  comparator flag: target > trial.
REQ-006 SHALL have port CC_SAR_SEARCH_lessthan_In  input  1  comparator flag: target < trial.
REQ-007 SHALL have port CC_SAR_SEARCH_equal_In  input  1  comparator flag: target == trial.
REQ-008 SHALL have port CC_SAR_SEARCH_trial_OutBUS  output  NUMBER_DATAWIDTH  trial value driven to the comparator B input.
REQ-009 SHALL have port CC_SAR_SEARCH_result_OutBUS  output  NUMBER_DATAWIDTH  final search value.
REQ-010 SHALL have port CC_SAR_SEARCH_found_Out  output  1  high when the search terminated on an equal flag.
REQ-011 SHALL have port CC_SAR_SEARCH_busy_Out  output  1  high while in TEST.
REQ-012 SHALL have port CC_SAR_SEARCH_done_Out  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement a successive-approximation search that acts as the initiator for an external combinational comparator (target on A, trial_OutBUS on B), with flags valid in the same cycle as the trial value.
REQ-014 SHALL use a three-state FSM: IDLE, TEST, DONE.
REQ-015 In IDLE, start_In=1 at a clock edge SHALL move the FSM to TEST, load the trial register with only the MSB set, load the bit index with NUMBER_DATAWIDTH-1, and clear result_OutBUS and found_Out.
REQ-016 In IDLE, start_In=0 SHALL leave the FSM and all registers unchanged.
REQ-017 In TEST, each clock edge SHALL resolve exactly one bit, applying flag priority equal > greaterthan > lessthan/none.
REQ-018 TEST with equal_In=1 SHALL load the current trial into the result register, set found, and move to DONE (early exit).
REQ-019 TEST with greaterthan_In=1 SHALL keep the current bit; otherwise (lessthan, no flag, or any illegal combination without equal) SHALL clear it.
REQ-020 TEST with bit index > 0 SHALL then set the next lower bit, decrement the index, and stay in TEST.
REQ-021 TEST with bit index = 0 SHALL load the resolved trial into the result register, leave found=0, and move to DONE.
REQ-022 DONE SHALL assert done_Out for exactly one cycle and return to IDLE on the next edge.
REQ-023 In DONE, start_In SHALL be ignored; start_In SHALL be accepted again from the first IDLE cycle.
REQ-024 start_In asserted in TEST SHALL be ignored and SHALL not alter the search.
REQ-025 busy_Out SHALL be 1 only in TEST; trial_OutBUS SHALL be 0 in IDLE and DONE.
REQ-026 result_OutBUS and found_Out SHALL hold their values from DONE until the next accepted start.
REQ-027 Latency SHALL be measured from the start-accepting edge E0: done_Out is high in the cycle after edge E(k), where k is the number of TEST cycles, 1 <= k <= NUMBER_DATAWIDTH.
REQ-028 Target 0 SHALL never produce an equal flag, so it SHALL yield result 0, found 0 and k = NUMBER_DATAWIDTH; every target > 0 SHALL end with found=1.
REQ-029 All outputs SHALL be driven from registers or from decoded state only, with no combinational path from the inputs.

Reset
REQ-030 RESET_InLow=0 SHALL immediately (asynchronously) force IDLE and set trial_OutBUS, result_OutBUS, found_Out, busy_Out and done_Out to 0, including during a search in progress.
REQ-031 After reset is released, the block SHALL accept start_In at the first rising edge.
REQ-032 A search interrupted by reset SHALL not resume and SHALL not pulse done_Out.

Verification
REQ-033 Target 0x80, start pulse -> one TEST cycle with trial 0x80, done at E1, result 0x80, found 1.
REQ-034 Target 0x5A -> trial sequence 80,40,60,50,58,5C,5A, done after E7, result 0x5A, found 1.
REQ-035 Target 0xFF -> trial sequence 80,C0,...,FF, done after E8, result 0xFF, found 1.
REQ-036 Target 0x00 -> trial sequence 80,40,20,10,08,04,02,01, done after E8, result 0x00, found 0.
REQ-037 Target 0x5A with start re-asserted during TEST -> result and timing identical to REQ-034, and no second search starts.
REQ-038 Reset asserted at the third TEST cycle -> all outputs 0 asynchronously, no done pulse; a fresh start then completes normally.

Source files
------------

// File: rtl/cc_sar_search_if.sv
// Interface for the successive-approximation search engine.
// The engine drives the trial value to an external comparator and reads its flags back.
interface cc_sar_search_if #(
    parameter int NUMBER_DATAWIDTH = 8
);
    logic                        CC_SAR_SEARCH_start_In;
    logic                        CC_SAR_SEARCH_greaterthan_In;
    logic                        CC_SAR_SEARCH_lessthan_In;
    logic                        CC_SAR_SEARCH_equal_In;
    logic [NUMBER_DATAWIDTH-1:0] CC_SAR_SEARCH_trial_OutBUS;
    logic [NUMBER_DATAWIDTH-1:0] CC_SAR_SEARCH_result_OutBUS;
    logic                        CC_SAR_SEARCH_found_Out;
    logic                        CC_SAR_SEARCH_busy_Out;
    logic                        CC_SAR_SEARCH_done_Out;
    logic [1:0]                  state_dbg;

    // Handshake: start is a level request sampled only in IDLE; the comparator flags
    // must be valid in the same cycle as trial; done is a single-cycle completion pulse.
    modport master (
        output CC_SAR_SEARCH_start_In, CC_SAR_SEARCH_greaterthan_In,
               CC_SAR_SEARCH_lessthan_In, CC_SAR_SEARCH_equal_In,
        input  CC_SAR_SEARCH_trial_OutBUS, CC_SAR_SEARCH_result_OutBUS,
               CC_SAR_SEARCH_found_Out, CC_SAR_SEARCH_busy_Out,
               CC_SAR_SEARCH_done_Out, state_dbg
    );

    modport slave (
        input  CC_SAR_SEARCH_start_In, CC_SAR_SEARCH_greaterthan_In,
               CC_SAR_SEARCH_lessthan_In, CC_SAR_SEARCH_equal_In,
        output CC_SAR_SEARCH_trial_OutBUS, CC_SAR_SEARCH_result_OutBUS,
               CC_SAR_SEARCH_found_Out, CC_SAR_SEARCH_busy_Out,
               CC_SAR_SEARCH_done_Out, state_dbg
    );
endinterface

// File: rtl/cc_sar_search.sv
// Successive-approximation search: resolves one bit per clock against an external
// comparator, exiting early when the comparator reports equality.
module cc_sar_search #(
    parameter int NUMBER_DATAWIDTH = 8
) (
    input  logic            CC_SAR_SEARCH_CLOCK_50,
    input  logic            CC_SAR_SEARCH_RESET_InLow,
    cc_sar_search_if.slave  bus
);
    localparam int W  = NUMBER_DATAWIDTH;
    localparam int IW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   trial;
    logic [IW-1:0]  bit_idx;
    logic [W-1:0]   result;
    logic           found;
    logic           busy;
    logic           done;

    logic [W-1:0]   one_w;
    logic [W-1:0]   cur_mask;
    logic [W-1:0]   next_mask;
    logic [W-1:0]   resolved;

    assign one_w = {{(W-1){1'b0}}, 1'b1};

    // Greater keeps the bit under test; anything else without equal clears it.
    always_comb begin
        cur_mask  = one_w << bit_idx;
        next_mask = one_w << (bit_idx - IW'(1));
        resolved  = bus.CC_SAR_SEARCH_greaterthan_In ? trial : (trial & ~cur_mask);
    end

    always_ff @(posedge CC_SAR_SEARCH_CLOCK_50 or negedge CC_SAR_SEARCH_RESET_InLow) begin
        if (!CC_SAR_SEARCH_RESET_InLow) begin
            state   <= IDLE;
            trial   <= '0;
            bit_idx <= '0;
            result  <= '0;
            found   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.CC_SAR_SEARCH_start_In) begin
                        state   <= TEST;
                        trial   <= one_w << (W-1);
                        bit_idx <= IW'(W-1);
                        result  <= '0;
                        found   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                TEST: begin
                    if (bus.CC_SAR_SEARCH_equal_In) begin
                        result <= trial;
                        found  <= 1'b1;
                        trial  <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (bit_idx == '0) begin
                        result <= resolved;
                        trial  <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        trial   <= resolved | next_mask;
                        bit_idx <= bit_idx - IW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    trial <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CC_SAR_SEARCH_trial_OutBUS  = trial;
    assign bus.CC_SAR_SEARCH_result_OutBUS = result;
    assign bus.CC_SAR_SEARCH_found_Out     = found;
    assign bus.CC_SAR_SEARCH_busy_Out      = busy;
    assign bus.CC_SAR_SEARCH_done_Out      = done;
    assign bus.state_dbg                   = state;
endmodule
